// File: rtl/hilo_pkg.sv
// Purpose: shared types and constants for the HI/LO multiply/divide unit.
// Latency: n/a (types only).
// Backpressure: n/a. Decode imports hilo_op_t to build the op field.
package hilo_pkg;

   localparam int DIV_ITERS = 32;

   typedef enum logic [2:0] {
      HOP_MULT  = 3'd0,
      HOP_MULTU = 3'd1,
      HOP_DIV   = 3'd2,
      HOP_DIVU  = 3'd3,
      HOP_MTHI  = 3'd4,
      HOP_MTLO  = 3'd5
   } hilo_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   // Magnitude of a two's-complement word; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Purpose: unsigned restoring divider core, one quotient bit per cycle.
// Latency: load, then ITERS step cycles; done is high during the last step.
// Backpressure: none; abort (or reset) stops the core immediately.
// Ports: clk, reset (sync, active-high), load/abort controls,
//        dividend/divisor in, quotient/remainder/done out.
module div_iter #(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   localparam int CW = $clog2(ITERS);

   logic          active;
   logic [CW-1:0] cnt;
   logic [31:0]   dvsr;
   logic [32:0]   shifted;
   logic          ge;

   // Dividend bits are consumed MSB-first out of the quotient register
   // while quotient bits shift in from the bottom.
   assign shifted = {remainder, quotient[31]};
   assign ge      = (shifted >= {1'b0, dvsr});
   assign done    = active & (cnt == CW'(ITERS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         active    <= 1'b0;
         cnt       <= '0;
         dvsr      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (abort) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         active    <= 1'b1;
         cnt       <= '0;
         dvsr      <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (active) begin
         // When ge holds the difference is below dvsr, so 32 bits suffice.
         remainder <= ge ? (shifted[31:0] - dvsr) : shifted[31:0];
         quotient  <= {quotient[30:0], ge};
         cnt       <= cnt + CW'(1);
         if (done) active <= 1'b0;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// Purpose: architectural HI/LO pair plus multi-cycle MULT/DIV datapath.
// Latency: MT* 1 cycle, MULT* 3 cycles, DIV* 34 cycles (start to visible).
// Backpressure: busy stalls issue; start while busy is illegal; flush aborts.
// Ports: clk, reset (sync, active-high), start/op/a/b/flush from execute,
//        busy to hazard, hi/lo committed registers to decode.
module hilo_unit #(
   parameter int DIV_ITERS = hilo_pkg::DIV_ITERS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  hilo_pkg::hilo_op_t op,
   input  logic [31:0]       a,
   input  logic [31:0]       b,
   input  logic              flush,
   output logic              busy,
   output logic [31:0]       hi,
   output logic [31:0]       lo
);

   import hilo_pkg::*;

   state_t             state, next_state;
   logic               accept, is_muldiv, is_div;
   logic               div_load, mul_wr, fix_wr;
   logic signed [32:0] ma, mb;
   logic signed [63:0] prod;
   logic               mul_cnt;
   logic               q_neg, r_neg, div_zero;
   logic [31:0]        quo, rem;
   logic               div_done;

   assign accept    = start & ~flush & (state == S_IDLE);
   assign is_muldiv = op inside {HOP_MULT, HOP_MULTU, HOP_DIV, HOP_DIVU};
   assign is_div    = op inside {HOP_DIV, HOP_DIVU};
   assign busy      = (accept & is_muldiv) | (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      div_load   = 1'b0;
      mul_wr     = 1'b0;
      fix_wr     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (op inside {HOP_MULT, HOP_MULTU}) next_state = S_MUL;
               else if (is_div) begin
                  next_state = S_DIV;
                  div_load   = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (mul_cnt) begin
               next_state = S_IDLE;
               mul_wr     = 1'b1;
            end
         end
         S_DIV: if (div_done) next_state = S_FIX;
         S_FIX: begin
            next_state = S_IDLE;
            // Divide by zero still runs the full length but commits nothing.
            fix_wr     = ~div_zero;
         end
         default: next_state = S_IDLE;
      endcase
      if (flush) begin
         next_state = S_IDLE;
         div_load   = 1'b0;
         mul_wr     = 1'b0;
         fix_wr     = 1'b0;
      end
   end

   // Multiply: operand registers, then product register, then commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         ma      <= '0;
         mb      <= '0;
         prod    <= '0;
         mul_cnt <= 1'b0;
      end else begin
         if (accept && (op inside {HOP_MULT, HOP_MULTU})) begin
            ma <= {(op == HOP_MULT) & a[31], a};
            mb <= {(op == HOP_MULT) & b[31], b};
         end
         prod    <= ma * mb;
         mul_cnt <= (state == S_MUL) ? ~mul_cnt : 1'b0;
      end
   end

   // Divide: core works on magnitudes; signs are reapplied in S_FIX.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         div_zero <= 1'b0;
      end else if (div_load) begin
         q_neg    <= (op == HOP_DIV) & (a[31] ^ b[31]);
         r_neg    <= (op == HOP_DIV) & a[31];
         div_zero <= (b == 32'd0);
      end
   end

   div_iter #(.ITERS(DIV_ITERS)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .abort     (flush),
      .dividend  ((op == HOP_DIV) ? abs32(a) : a),
      .divisor   ((op == HOP_DIV) ? abs32(b) : b),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (mul_wr) begin
         hi <= prod[63:32];
         lo <= prod[31:0];
      end else if (fix_wr) begin
         lo <= q_neg ? (~quo + 32'd1) : quo;
         hi <= r_neg ? (~rem + 32'd1) : rem;
      end else if (accept && op == HOP_MTHI) begin
         hi <= a;
      end else if (accept && op == HOP_MTLO) begin
         lo <= a;
      end
   end

   a_no_start_when_busy: assert property (@(posedge clk) disable iff (reset)
      !(start && state != S_IDLE));

endmodule

// File: tb/tb_hilo_unit.sv
// Purpose: directed self-checking bench for hilo_unit.
// Latency: n/a.
// Backpressure: n/a.
module tb_hilo_unit;
   import hilo_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   hilo_op_t    op = HOP_MTHI;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   hilo_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   // Called mid-cycle; start is applied in the current cycle (cycle 0).
   // Returns mid-cycle in the first cycle the result is visible, with the
   // number of cycles busy was high (-1 if it never dropped).
   task automatic run_op(input hilo_op_t o, input logic [31:0] x, input logic [31:0] y,
                         output int nb);
      nb = 0;
      op = o; a = x; b = y; start = 1'b1;
      #1;
      while (busy === 1'b1 && nb < 100) begin
         nb++;
         @(negedge clk); start = 1'b0; #1;
      end
      if (nb == 0) begin
         @(negedge clk); start = 1'b0; #1;
      end
      if (nb >= 100) nb = -1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0; #1;
      vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
      vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_mt;
      int nb;
      run_op(HOP_MTHI, 32'h12345678, 32'h0, nb);
      vectors++; if (nb !== 0) begin miscompares++; $display("FAIL mthi_busy got=%0d exp=0", nb); end
      vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
      vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL mthi_lo got=%h exp=0", lo); end
      run_op(HOP_MTLO, 32'hCAFEF00D, 32'h0, nb);
      vectors++; if (lo !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mtlo_lo got=%h exp=cafef00d", lo); end
      vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mtlo_hi got=%h exp=12345678", hi); end
   endtask

   task automatic test_mult;
      int nb;
      run_op(HOP_MULT, 32'hFFFFFFFE, 32'd3, nb);
      vectors++; if (nb !== 3) begin miscompares++; $display("FAIL mult_busy got=%0d exp=3", nb); end
      vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
      vectors++; if (lo !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
      run_op(HOP_MULTU, 32'hFFFFFFFE, 32'd3, nb);
      vectors++; if (nb !== 3) begin miscompares++; $display("FAIL multu_busy got=%0d exp=3", nb); end
      vectors++; if (hi !== 32'h00000002) begin miscompares++; $display("FAIL multu_hi got=%h exp=00000002", hi); end
      vectors++; if (lo !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
      run_op(HOP_MULT, 32'h80000000, 32'h7FFFFFFF, nb);
      vectors++; if (hi !== 32'hC0000000) begin miscompares++; $display("FAIL mult_min_hi got=%h exp=c0000000", hi); end
      vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL mult_min_lo got=%h exp=80000000", lo); end
   endtask

   task automatic test_div;
      int nb;
      run_op(HOP_DIV, 32'hFFFFFFF9, 32'd2, nb);
      vectors++; if (nb !== 34) begin miscompares++; $display("FAIL div_busy got=%0d exp=34", nb); end
      vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
      vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
      run_op(HOP_DIVU, 32'd7, 32'd2, nb);
      vectors++; if (nb !== 34) begin miscompares++; $display("FAIL divu_busy got=%0d exp=34", nb); end
      vectors++; if (lo !== 32'd3) begin miscompares++; $display("FAIL divu_lo got=%h exp=3", lo); end
      vectors++; if (hi !== 32'd1) begin miscompares++; $display("FAIL divu_hi got=%h exp=1", hi); end
      run_op(HOP_DIV, 32'd7, 32'hFFFFFFFE, nb);
      vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_negb_lo got=%h exp=fffffffd", lo); end
      vectors++; if (hi !== 32'd1) begin miscompares++; $display("FAIL div_negb_hi got=%h exp=1", hi); end
      run_op(HOP_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
      vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
      vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
      run_op(HOP_DIVU, 32'hFFFFFFFF, 32'h10, nb);
      vectors++; if (lo !== 32'h0FFFFFFF) begin miscompares++; $display("FAIL divu_big_lo got=%h exp=0fffffff", lo); end
      vectors++; if (hi !== 32'hF) begin miscompares++; $display("FAIL divu_big_hi got=%h exp=f", hi); end
   endtask

   task automatic test_div_zero;
      int nb;
      run_op(HOP_MTHI, 32'hAA, 32'h0, nb);
      run_op(HOP_MTLO, 32'hBB, 32'h0, nb);
      run_op(HOP_DIVU, 32'd5, 32'd0, nb);
      vectors++; if (nb !== 34) begin miscompares++; $display("FAIL divz_busy got=%0d exp=34", nb); end
      vectors++; if (hi !== 32'hAA) begin miscompares++; $display("FAIL divz_hi got=%h exp=aa", hi); end
      vectors++; if (lo !== 32'hBB) begin miscompares++; $display("FAIL divz_lo got=%h exp=bb", lo); end
      run_op(HOP_DIV, 32'hFFFFFFF0, 32'd0, nb);
      vectors++; if (hi !== 32'hAA || lo !== 32'hBB) begin
         miscompares++; $display("FAIL divz_signed got=%h/%h exp=aa/bb", hi, lo);
      end
   endtask

   task automatic test_flush;
      int nb;
      run_op(HOP_MTHI, 32'h11, 32'h0, nb);
      run_op(HOP_MTLO, 32'h22, 32'h0, nb);
      op = HOP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
      #1;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy_c0 got=%b exp=1", busy); end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); start = 1'b0;
         if (c == 10) flush = 1'b1;
         #1;
      end
      @(negedge clk); flush = 1'b0; #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy_c11 got=%b exp=0", busy); end
      vectors++; if (hi !== 32'h11 || lo !== 32'h22) begin
         miscompares++; $display("FAIL flush_hilo got=%h/%h exp=11/22", hi, lo);
      end
      run_op(HOP_MULT, 32'd5, 32'd6, nb);
      vectors++; if (nb !== 3) begin miscompares++; $display("FAIL b2b_busy got=%0d exp=3", nb); end
      vectors++; if (lo !== 32'd30) begin miscompares++; $display("FAIL b2b_lo got=%h exp=1e", lo); end
      vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL b2b_hi got=%h exp=0", hi); end
   endtask

   task automatic test_start_flush;
      op = HOP_MTLO; a = 32'd1; start = 1'b1; flush = 1'b1;
      @(negedge clk); start = 1'b0; flush = 1'b0; #1;
      vectors++; if (lo !== 32'd30) begin miscompares++; $display("FAIL sf_mtlo got=%h exp=1e", lo); end
      op = HOP_DIV; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sf_div_busy_c0 got=%b exp=0", busy); end
      @(negedge clk); start = 1'b0; flush = 1'b0; #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sf_div_busy_c1 got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      int nb;
      op = HOP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); start = 1'b0;
         if (c == 5) reset = 1'b1;
         #1;
      end
      @(negedge clk); reset = 1'b0; #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin
         miscompares++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", hi, lo);
      end
      run_op(HOP_DIVU, 32'd9, 32'd4, nb);
      vectors++; if (nb !== 34 || lo !== 32'd2 || hi !== 32'd1) begin
         miscompares++; $display("FAIL rst_recover got=busy%0d %h/%h exp=busy34 1/2", nb, hi, lo);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_mt;
      test_mult;
      test_div;
      test_div_zero;
      test_flush;
      test_start_flush;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Owns the architectural HI/LO register pair and the multi-cycle multiply/divide datapath that writes it. Decode reads `hi`/`lo` for MFHI/MFLO; this block is the writer side of that interface. Execute issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here, and hazard stalls on `busy`.

## Interface
Parameters:
- `DIV_ITERS`, 32, radix-2 divide iterations; fixed by the 32-bit word, not for tuning.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  op valid from execute, sampled at the rising edge.
- `op`  in  3  `hilo_op_t`: HOP_MULT, HOP_MULTU, HOP_DIV, HOP_DIVU, HOP_MTHI, HOP_MTLO.
- `a`  in  32  rs operand (dividend / multiplicand / MT source).
- `b`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  hazard flush of the issuing stage; aborts in-flight op.
- `busy`  out  1  to hazard; stall MFHI/MFLO and new HI/LO ops.
- `hi`  out  32  committed HI, to decode.
- `lo`  out  32  committed LO, to decode.

## Operation
- State `state_t`: S_IDLE, S_MUL, S_DIV, S_FIX. Reset values: `state`=S_IDLE, `hi`=`lo`=0, `busy`=0.
- `busy` = (`start` & op∈{MULT,MULTU,DIV,DIVU} & ~`flush` & state==S_IDLE) | (state≠S_IDLE).
- S_IDLE + `start`:
  - MTHI: `hi`←`a`. MTLO: `lo`←`a`. Stay in S_IDLE.
  - MULT/MULTU: latch operands (sign- or zero-extended to 33 bits) → S_MUL, counter=0.
  - DIV/DIVU: latch |a| and |b| (signed) or raw values (unsigned). Record quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only). Record b==0 → S_DIV, counter=0.
- S_MUL: two-stage registered 33×33 signed product. After 2 cycles, write {hi,lo}←product[63:0] → S_IDLE.
- S_DIV: one restoring step per cycle, 32 cycles, shifting the quotient into a partial-remainder register → S_FIX.
- S_FIX: negate the quotient and/or remainder per the recorded signs. Write `lo`←quotient, `hi`←remainder → S_IDLE.
- Divide by zero: full duration runs; `hi`/`lo` are NOT written.
- Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (natural 32-bit wrap).
- `flush` (any state): next state S_IDLE, no HI/LO write, pending result discarded. `flush` and `start` in the same cycle: flush wins, op dropped, MT* not written.
- `start` while state≠S_IDLE: ignored, protocol violation, covered by an assertion.
- `reset` mid-operation: S_IDLE and HI=LO=0 at the next edge.

## Timing
- Cycle 0 is the cycle `start` is sampled.
- MTHI/MTLO: new value visible on `hi`/`lo` in cycle 1. `busy` is never asserted.
- MULT/MULTU: `busy` high in cycles 0–2. Result visible in cycle 3, with `busy` low.
- DIV/DIVU: `busy` high in cycles 0–33 (latch, 32 steps, fix). Result visible in cycle 34.
- `hi`/`lo` are register outputs with no combinational path from inputs. A back-to-back op may start in the first cycle `busy` is low.

## Structure
- Shared package `hilo_pkg`: `hilo_op_t`, `state_t`, `DIV_ITERS`. Decode's decoder imports `hilo_op_t` to generate `op`.
- One sub-module, `div_iter`: the restoring divide core (operand load, 32-step shift/subtract, done pulse). The FSM, multiply pipeline, sign fix and HI/LO registers live in `hilo_unit`.

## Test plan
- Reset then MTHI a=0x12345678 → cycle 1: hi=0x12345678, lo=0, busy never high.
- MULT a=0xFFFFFFFE (−2), b=3 → busy cycles 0–2. Cycle 3: hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU of the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy 34 cycles, then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU 7/2 → lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU by 0 with prior hi=0xAA, lo=0xBB → busy 34 cycles, hi/lo stay 0xAA/0xBB.
- Start DIV, assert flush in cycle 10 → cycle 11: busy=0, hi/lo unchanged. An immediate MULT 5×6 then yields lo=30, hi=0 in 3 cycles.
- start+flush in the same cycle with MTLO a=1 → lo unchanged. Reset asserted in cycle 5 of a DIV → next cycle busy=0, hi=lo=0.
